// File: rtl/sram_pkg.sv
// Shared definitions for the parametrised SRAM models: clog2, FSM encodings and
// the legal-latency check macro used by every parametrised memory wrapper.
`ifndef SRAM_PKG_SV
`define SRAM_PKG_SV

`define SRAM_LATENCY_LEGAL(lat) (((lat) == 1) || ((lat) == 2))

package sram_pkg;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } sram_state_t;

   // Never returns less than 1 so a 2-word array still gets an address bit.
   function automatic int clog2(input int n);
      int r;
      r = 1;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

`endif

// File: rtl/sram_rd_pipe.sv
// Read output stage: carries data/valid/perr through 1 or 2 registers, holds
// data between reads and flushes on reset.
module sram_rd_pipe #(
   parameter int WIDTH   = 32,
   parameter int LATENCY = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             rd_valid,
   input  logic [WIDTH-1:0] rd_data,
   input  logic             rd_perr,
   output logic             q_valid,
   output logic [WIDTH-1:0] q_data,
   output logic             q_perr
);

   logic             s1_valid;
   logic             s1_perr;
   logic [WIDTH-1:0] s1_data;

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_perr  <= 1'b0;
         s1_data  <= '0;
      end else begin
         s1_valid <= rd_valid;
         s1_perr  <= rd_valid & rd_perr;
         if (rd_valid) s1_data <= rd_data;
      end
   end

   generate
      if (LATENCY == 2) begin : g_lat2
         logic             s2_valid;
         logic             s2_perr;
         logic [WIDTH-1:0] s2_data;

         always_ff @(posedge clk) begin
            if (reset) begin
               s2_valid <= 1'b0;
               s2_perr  <= 1'b0;
               s2_data  <= '0;
            end else begin
               s2_valid <= s1_valid;
               s2_perr  <= s1_perr;
               if (s1_valid) s2_data <= s1_data;
            end
         end

         assign q_valid = s2_valid;
         assign q_data  = s2_data;
         assign q_perr  = s2_perr;
      end else begin : g_lat1
         assign q_valid = s1_valid;
         assign q_data  = s1_data;
         assign q_perr  = s1_perr;
      end
   endgenerate

endmodule

// File: rtl/sram_1rw_param.sv
// Parametrised 1RW synchronous SRAM with post-reset zeroize and read-valid strobe.
// Optional per-granule even parity is enabled by defining SRAM_PARITY_EN.
module sram_1rw_param
   import sram_pkg::*;
#(
   parameter int  DEPTH   = 4096,
   parameter int  WIDTH   = 32,
   parameter int  GRAN    = 8,
   parameter int  LATENCY = 1,
   localparam int ADDR_W  = clog2(DEPTH),
   localparam int NGRAN   = WIDTH / GRAN
) (
   input  logic              RW0_clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] RW0_addr,
   input  logic              RW0_en,
   input  logic              RW0_wmode,
   input  logic [NGRAN-1:0]  RW0_wmask,
   input  logic [WIDTH-1:0]  RW0_wdata,
   output logic [WIDTH-1:0]  RW0_rdata,
   output logic              RW0_rvalid,
   output logic              RW0_ready,
   output logic              RW0_perr
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   generate
      if (!`SRAM_LATENCY_LEGAL(LATENCY)) begin : g_bad_latency
         $error("sram_1rw_param: LATENCY must be 1 or 2");
      end
      if ((WIDTH % GRAN) != 0) begin : g_bad_gran
         $error("sram_1rw_param: WIDTH must be a multiple of GRAN");
      end
      if (DEPTH < 2) begin : g_bad_depth
         $error("sram_1rw_param: DEPTH must be at least 2");
      end
   endgenerate

   sram_state_t       state_q, state_d;
   logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
   logic [WIDTH-1:0]  ram [DEPTH];
   logic              in_range;
   logic              wr_acc;
   logic              rd_acc;
   logic [WIDTH-1:0]  rd_word;
   logic              rd_perr;

   assign RW0_ready = (state_q == ST_IDLE);
   assign in_range  = (32'(RW0_addr) < 32'(DEPTH));
   // A request coinciding with a reset edge must not touch the array.
   assign wr_acc    = RW0_en & RW0_ready & ~reset & RW0_wmode;
   assign rd_acc    = RW0_en & RW0_ready & ~reset & ~RW0_wmode;

   always_ff @(posedge RW0_clk) begin
      if (reset) begin
         state_q   <= ST_CLEAR;
         clr_ptr_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_ptr_q <= clr_ptr_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      clr_ptr_d = clr_ptr_q;
      case (state_q)
         ST_CLEAR: begin
            clr_ptr_d = clr_ptr_q + ADDR_W'(1);
            if (clr_ptr_q == LAST_ADDR) begin
               state_d   = ST_IDLE;
               clr_ptr_d = '0;
            end
         end
         ST_IDLE: state_d = ST_IDLE;
         default: state_d = ST_CLEAR;
      endcase
   end

`ifdef SRAM_PARITY_EN
   logic [NGRAN-1:0] par [DEPTH];
`endif

   // Array contents are never reset; zeroize walks them instead.
   always_ff @(posedge RW0_clk) begin
      if (state_q == ST_CLEAR) begin
         ram[clr_ptr_q] <= '0;
`ifdef SRAM_PARITY_EN
         par[clr_ptr_q] <= '0;
`endif
      end else if (wr_acc && in_range) begin
         for (int g = 0; g < NGRAN; g++) begin
            if (RW0_wmask[g]) begin
               ram[RW0_addr][g*GRAN +: GRAN] <= RW0_wdata[g*GRAN +: GRAN];
`ifdef SRAM_PARITY_EN
               par[RW0_addr][g] <= ^RW0_wdata[g*GRAN +: GRAN];
`endif
            end
         end
      end
   end

   always_comb begin
      rd_word = '0;
      rd_perr = 1'b0;
      if (in_range) begin
         rd_word = ram[RW0_addr];
`ifdef SRAM_PARITY_EN
         for (int g = 0; g < NGRAN; g++) begin
            if ((^rd_word[g*GRAN +: GRAN]) != par[RW0_addr][g]) rd_perr = 1'b1;
         end
`endif
      end
   end

   sram_rd_pipe #(
      .WIDTH   (WIDTH),
      .LATENCY (LATENCY)
   ) u_rd_pipe (
      .clk      (RW0_clk),
      .reset    (reset),
      .rd_valid (rd_acc),
      .rd_data  (rd_word),
      .rd_perr  (rd_perr),
      .q_valid  (RW0_rvalid),
      .q_data   (RW0_rdata),
      .q_perr   (RW0_perr)
   );

endmodule

// File: tb/tb_sram_1rw_param.sv
// Directed bench for sram_1rw_param with DEPTH=12 (non-power-of-two) and LATENCY=2.
// Parity checks adapt to whether SRAM_PARITY_EN is defined.
module tb_sram_1rw_param;

   localparam int DEPTH   = 12;
   localparam int WIDTH   = 32;
   localparam int GRAN    = 8;
   localparam int LATENCY = 2;
   localparam int ADDR_W  = 4;
   localparam int NGRAN   = 4;

   logic              clk;
   logic              reset;
   logic [ADDR_W-1:0] addr;
   logic              en;
   logic              wmode;
   logic [NGRAN-1:0]  wmask;
   logic [WIDTH-1:0]  wdata;
   logic [WIDTH-1:0]  rdata;
   logic              rvalid;
   logic              ready;
   logic              perr;

   int total = 0;
   int bad   = 0;

   sram_1rw_param #(
      .DEPTH   (DEPTH),
      .WIDTH   (WIDTH),
      .GRAN    (GRAN),
      .LATENCY (LATENCY)
   ) dut (
      .RW0_clk    (clk),
      .reset      (reset),
      .RW0_addr   (addr),
      .RW0_en     (en),
      .RW0_wmode  (wmode),
      .RW0_wmask  (wmask),
      .RW0_wdata  (wdata),
      .RW0_rdata  (rdata),
      .RW0_rvalid (rvalid),
      .RW0_ready  (ready),
      .RW0_perr   (perr)
   );

   // clock/reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // driver tasks: each issues one request at the next edge, then idles the port
   task automatic do_write(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d,
                           input logic [NGRAN-1:0] m);
      en = 1'b1; wmode = 1'b1; addr = a; wdata = d; wmask = m;
      tick();
      en = 1'b0; wmode = 1'b0;
   endtask

   task automatic do_read(input logic [ADDR_W-1:0] a);
      en = 1'b1; wmode = 1'b0; addr = a;
      tick();
      en = 1'b0;
   endtask

   initial begin
      int cnt;
      logic rv_seen;

      reset = 1'b1; en = 1'b0; wmode = 1'b0; addr = '0; wmask = '0; wdata = '0;
      repeat (3) tick();
      chk("reset_ready",  {31'd0, ready},  32'd0);
      chk("reset_rvalid", {31'd0, rvalid}, 32'd0);
      chk("reset_rdata",  rdata,           32'd0);
      chk("reset_perr",   {31'd0, perr},   32'd0);

      // release, then abort the clear after five cycles
      reset = 1'b0;
      repeat (5) tick();
      chk("clear_not_ready", {31'd0, ready}, 32'd0);
      reset = 1'b1;
      tick();
      reset = 1'b0;

      // full clear from zero; requests during CLEAR must be dropped
      cnt = 0; rv_seen = 1'b0;
      while (!ready && cnt < 64) begin
         en = 1'b0; wmode = 1'b0;
         if (cnt == 8) begin
            en = 1'b1; wmode = 1'b1; addr = 4'd0; wdata = 32'hFFFF_FFFF; wmask = 4'hF;
         end else if (cnt == 9 || cnt == 11) begin
            en = 1'b1; wmode = 1'b0; addr = 4'd0;
         end
         tick();
         cnt++;
         rv_seen = rv_seen | rvalid;
      end
      en = 1'b0; wmode = 1'b0;
      chk("ready_latency", cnt, DEPTH);
      repeat (3) begin
         tick();
         rv_seen = rv_seen | rvalid;
      end
      chk("clear_no_rvalid", {31'd0, rv_seen}, 32'd0);

      // read every address back-to-back: all zero, one rvalid per read
      for (int i = 0; i <= DEPTH; i++) begin
         if (i < DEPTH) begin
            en = 1'b1; wmode = 1'b0; addr = ADDR_W'(i);
         end else begin
            en = 1'b0;
         end
         tick();
         if (i >= 1) begin
            chk($sformatf("zero_rvalid_%0d", i - 1), {31'd0, rvalid}, 32'd1);
            chk($sformatf("zero_rdata_%0d", i - 1),  rdata,           32'd0);
         end
      end
      tick();
      chk("zero_rvalid_end", {31'd0, rvalid}, 32'd0);

      // masked writes
      do_write(4'd3, 32'hAABB_CCDD, 4'b1111);
      do_write(4'd3, 32'h1122_3344, 4'b0101);
      do_write(4'd3, 32'h0000_0000, 4'b0000);
      do_read(4'd3);
      tick();
      chk("mask_rvalid", {31'd0, rvalid}, 32'd1);
      chk("mask_rdata",  rdata,           32'hAA22_CC44);
      chk("mask_perr",   {31'd0, perr},   32'd0);

      // latency 2 with back-to-back reads, then hold
      do_write(4'd5, 32'h1234_5678, 4'hF);
      do_read(4'd5);
      chk("lat_early_rvalid", {31'd0, rvalid}, 32'd0);
      do_read(4'd3);
      chk("b2b_rvalid_0", {31'd0, rvalid}, 32'd1);
      chk("b2b_rdata_0",  rdata,           32'h1234_5678);
      tick();
      chk("b2b_rvalid_1", {31'd0, rvalid}, 32'd1);
      chk("b2b_rdata_1",  rdata,           32'hAA22_CC44);
      tick();
      chk("hold_rvalid", {31'd0, rvalid}, 32'd0);
      chk("hold_rdata",  rdata,           32'hAA22_CC44);

      // read then write same address: read sees pre-write data, write leaves rdata alone
      do_read(4'd5);
      do_write(4'd5, 32'hDEAD_BEEF, 4'hF);
      chk("rbw_rvalid", {31'd0, rvalid}, 32'd1);
      chk("rbw_rdata",  rdata,           32'h1234_5678);
      tick();
      tick();
      chk("rbw_hold_rvalid", {31'd0, rvalid}, 32'd0);
      chk("rbw_hold_rdata",  rdata,           32'h1234_5678);
      do_read(4'd5);
      tick();
      chk("rbw_new_rdata", rdata, 32'hDEAD_BEEF);

      // out-of-range addresses
      do_write(4'd11, 32'h0BAD_CAFE, 4'hF);
      do_write(4'd13, 32'hFFFF_FFFF, 4'hF);
      do_write(4'd12, 32'hFFFF_FFFF, 4'hF);
      do_read(4'd13);
      tick();
      chk("oor13_rvalid", {31'd0, rvalid}, 32'd1);
      chk("oor13_rdata",  rdata,           32'd0);
      do_read(4'd11);
      tick();
      chk("last_addr_rdata", rdata, 32'h0BAD_CAFE);
      do_read(4'd12);
      tick();
      chk("oor12_rvalid", {31'd0, rvalid}, 32'd1);
      chk("oor12_rdata",  rdata,           32'd0);

      // parity
      do_write(4'd7, 32'h0000_0001, 4'hF);
`ifdef SRAM_PARITY_EN
      dut.ram[7][8] = ~dut.ram[7][8];
      do_read(4'd7);
      tick();
      chk("par_err_rvalid", {31'd0, rvalid}, 32'd1);
      chk("par_err_rdata",  rdata,           32'h0000_0101);
      chk("par_err_perr",   {31'd0, perr},   32'd1);
      tick();
      chk("par_err_cleared", {31'd0, perr}, 32'd0);
`else
      do_read(4'd7);
      tick();
      chk("par_off_rvalid", {31'd0, rvalid}, 32'd1);
      chk("par_off_rdata",  rdata,           32'h0000_0001);
      chk("par_off_perr",   {31'd0, perr},   32'd0);
`endif
      do_read(4'd11);
      tick();
      chk("par_clean_rdata", rdata,         32'h0BAD_CAFE);
      chk("par_clean_perr",  {31'd0, perr}, 32'd0);

      // reset discards a read in flight
      do_read(4'd3);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("flush_rvalid", {31'd0, rvalid}, 32'd0);
      chk("flush_rdata",  rdata,           32'd0);
      chk("flush_ready",  {31'd0, ready},  32'd0);

      // final report
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
